ulpi_reg_arb: RTL and testbench
===============================

ULPI_REG_ARB -- requirements
Module: ulpi_reg_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of register-access requesters.
REQ-002 SHALL have parameter TO_CYCLES, default 1024, SIE handshake timeout in clk cycles (used only with ULPI_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NREQ  per-requester access request, level, held until done.
REQ-006 SHALL have port req_cmd  input  NREQ*8  per-requester ULPI command byte (slice i = bits 8i+7:8i).
REQ-007 SHALL have port req_wd  input  NREQ*8  per-requester register write data.
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, held for the whole transaction.
REQ-009 SHALL have port done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rd  output  8  last register read data.
REQ-011 SHALL have port err  output  1  qualifies done: transaction aborted by timeout.
REQ-012 SHALL have ports sie_en output 1, sie_busy input 1, cmd output 8, regwd output 8, regrd input 8: shared SIE register-access engine.

Function
REQ-013 SHALL implement states IDLE, WACK, WDONE.
REQ-014 IDLE: when any req bit set and sie_busy=0, SHALL select winner round-robin starting at pointer ptr, latch cmd/regwd from winner slices, set gnt[winner], set sie_en=1, go WACK; with sie_busy=1 SHALL stay IDLE, no grant.
REQ-015 WACK: on sie_busy=1 SHALL clear sie_en and go WDONE; else hold sie_en=1.
REQ-016 WDONE: on sie_busy=0 SHALL pulse done[winner] one cycle, clear gnt, set ptr=(winner+1) mod NREQ, go IDLE.
REQ-017 On WDONE exit with cmd[7:6]=2'b11 (register read) SHALL load rd<=regrd same edge; writes SHALL leave rd unchanged.
REQ-018 cmd/regwd SHALL stay stable from sie_en rise until done.
REQ-019 req deasserted mid-transaction SHALL be ignored; transaction completes and done still pulses.
REQ-020 done[i] and gnt of next transaction SHALL never coincide; at least one IDLE cycle separates transactions.
REQ-021 Simultaneous requests SHALL be served one each in round-robin order; no requester starves while holding req.
REQ-022 Latency: sie_en rises one cycle after req sampled in IDLE; done pulses one cycle after sie_busy falls in WDONE.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, gnt=0, done=0, sie_en=0, cmd=0, regwd=0, rd=0, err=0, ptr=0, timeout counter=0.
REQ-024 Reset mid-transaction SHALL drop sie_en immediately with no done pulse; SIE recovery is outside this block.

Configuration
REQ-025 With ULPI_ARB_TIMEOUT_EN defined, a counter SHALL count cycles in WACK and WDONE; reaching TO_CYCLES SHALL clear sie_en, pulse done[winner] with err=1, leave rd unchanged, advance ptr, go IDLE.
REQ-026 Without ULPI_ARB_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied 0, WACK/WDONE wait indefinitely.

Structure
REQ-027 Package ulpi_pkg SHALL hold ULPI command prefixes (REGW=2'b10, REGR=2'b11), state encodings and default TO_CYCLES.
REQ-028 Round-robin selection SHALL be sub-module rr_pick (inputs req, ptr; outputs one-hot winner, any).

Verification
REQ-029 req=3'b001, req_cmd[0]=8'h84, req_wd[0]=8'h65; SIE model busy 2 cycles after sie_en, 4 cycles long -> cmd=8'h84, regwd=8'h65, done=3'b001 once, rd=0.
REQ-030 req=3'b111 held, ptr=0 -> grants 001,010,100,001 in order, each separated by IDLE cycle.
REQ-031 req[1] read cmd=8'hC5, regrd=8'h24 at busy fall -> rd=8'h24 with done=3'b010.
REQ-032 sie_busy=1 at request -> gnt stays 0, sie_en stays 0 until busy drops.
REQ-033 ULPI_ARB_TIMEOUT_EN, TO_CYCLES=16, busy never rises -> after 16 cycles sie_en=0, done[winner]=1 with err=1; macro off -> stays WACK, err=0.
REQ-034 rst_n=0 during WDONE -> all outputs zero same cycle, no done pulse; after release req=3'b010 granted first (ptr=0 scan).

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register-access arbiter: command prefixes,
// FSM encoding and the default SIE handshake timeout.
package ulpi_pkg;

  localparam logic [1:0] ULPI_REGW = 2'b10;
  localparam logic [1:0] ULPI_REGR = 2'b11;

  localparam int ULPI_TO_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WACK  = 2'd1,
    ST_WDONE = 2'd2
  } arb_state_e;

  function automatic logic is_reg_read(input logic [7:0] c);
    return (c[7:6] == ULPI_REGR);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester pick: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic            any
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ulpi_reg_arb.sv
// Arbitrates NREQ register-access requesters onto one shared SIE register engine.
// Optional SIE handshake timeout enabled by defining ULPI_ARB_TIMEOUT_EN.
module ulpi_reg_arb
  import ulpi_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int TO_CYCLES = ULPI_TO_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_cmd,
  input  logic [NREQ*8-1:0] req_wd,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rd,
  output logic              err,
  output logic              sie_en,
  input  logic              sie_busy,
  output logic [7:0]        cmd,
  output logic [7:0]        regwd,
  input  logic [7:0]        regrd
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            sie_en_q, sie_en_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      regwd_q, regwd_d;
  logic [7:0]      rd_q, rd_d;

  logic [NREQ-1:0] pick_win;
  logic            pick_any;
  logic [7:0]      pick_cmd, pick_wd;
  logic [IW-1:0]   win_idx, ptr_nxt;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_win),
    .any    (pick_any)
  );

  always_comb begin
    pick_cmd = '0;
    pick_wd  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win[i]) begin
        pick_cmd = req_cmd[8*i +: 8];
        pick_wd  = req_wd[8*i +: 8];
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) win_idx = IW'(i);
    end
    ptr_nxt = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

`ifdef ULPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
  logic          to_hit;

  assign to_hit = (to_cnt_q == TW'(TO_CYCLES - 1));
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (TO_CYCLES == 0);
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    ptr_d    = ptr_q;
    sie_en_d = sie_en_q;
    cmd_d    = cmd_q;
    regwd_d  = regwd_q;
    rd_d     = rd_q;
`ifdef ULPI_ARB_TIMEOUT_EN
    err_d    = 1'b0;
    to_cnt_d = (state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_any && !sie_busy) begin
          gnt_d    = pick_win;
          cmd_d    = pick_cmd;
          regwd_d  = pick_wd;
          sie_en_d = 1'b1;
          state_d  = ST_WACK;
        end
      end
      ST_WACK: begin
        if (sie_busy) begin
          sie_en_d = 1'b0;
          state_d  = ST_WDONE;
        end
      end
      ST_WDONE: begin
        if (!sie_busy) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          state_d = ST_IDLE;
          if (is_reg_read(cmd_q)) rd_d = regrd;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        sie_en_d = 1'b0;
      end
    endcase

`ifdef ULPI_ARB_TIMEOUT_EN
    // Abort wins over a coincident normal step; read data is not trusted.
    if (state_q != ST_IDLE && to_hit) begin
      sie_en_d = 1'b0;
      done_d   = gnt_q;
      err_d    = 1'b1;
      gnt_d    = '0;
      ptr_d    = ptr_nxt;
      rd_d     = rd_q;
      state_d  = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      ptr_q    <= '0;
      sie_en_q <= 1'b0;
      cmd_q    <= '0;
      regwd_q  <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      ptr_q    <= ptr_d;
      sie_en_q <= sie_en_d;
      cmd_q    <= cmd_d;
      regwd_q  <= regwd_d;
      rd_q     <= rd_d;
    end
  end

`ifdef ULPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rd     = rd_q;
  assign sie_en = sie_en_q;
  assign cmd    = cmd_q;
  assign regwd  = regwd_q;

endmodule

// File: tb/tb_ulpi_reg_arb.sv
// Directed scoreboard bench for ulpi_reg_arb with a scripted SIE handshake.
// Timeout expectations follow ULPI_ARB_TIMEOUT_EN.
module tb_ulpi_reg_arb;

  localparam int NREQ   = 3;
  localparam int TO_CYC = 16;

  typedef struct packed {
    logic [2:0] done;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [NREQ*8-1:0] req_cmd;
  logic [NREQ*8-1:0] req_wd;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done;
  logic [7:0]       rd;
  logic             err;
  logic             sie_en;
  logic             sie_busy;
  logic [7:0]       cmd;
  logic [7:0]       regwd;
  logic [7:0]       regrd;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ulpi_reg_arb #(
    .NREQ      (NREQ),
    .TO_CYCLES (TO_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_wd   (req_wd),
    .gnt      (gnt),
    .done     (done),
    .rd       (rd),
    .err      (err),
    .sie_en   (sie_en),
    .sie_busy (sie_busy),
    .cmd      (cmd),
    .regwd    (regwd),
    .regrd    (regrd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [2:0] d, input logic [7:0] r, input logic e);
    exp_t x;
    x.done = d;
    x.rd   = r;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t x;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      chk({tag, "_done"}, done, x.done);
      chk({tag, "_rd"}, rd, x.rd);
      chk({tag, "_err"}, err, x.err);
    end
  endtask

  task automatic wait_sie_en(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sie_en && n < 40);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 40);
  endtask

  // One full handshake: grant, SIE busy after dly cycles for len cycles, done.
  task automatic run_txn(input string tag, input logic [2:0] eg, input logic [7:0] ec,
                         input logic [7:0] ew, input int en_lat, input int dly,
                         input int len, input logic [7:0] rv, input logic [7:0] er,
                         input bit drop);
    int n;
    push_exp(eg, er, 1'b0);
    wait_sie_en(n);
    chk({tag, "_en_lat"}, n, en_lat);
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_cmd"}, cmd, ec);
    chk({tag, "_regwd"}, regwd, ew);
    if (drop) req = '0;
    repeat (dly) @(negedge clk);
    sie_busy = 1'b1;
    repeat (len) @(negedge clk);
    chk({tag, "_en_clr"}, sie_en, 1'b0);
    chk({tag, "_cmd_hold"}, cmd, ec);
    chk({tag, "_gnt_hold"}, gnt, eg);
    sie_busy = 1'b0;
    regrd    = rv;
    wait_done(n);
    chk({tag, "_done_lat"}, n, 1);
    pop_cmp(tag);
    chk({tag, "_gnt_clr"}, gnt, 3'b000);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    req      = '0;
    req_cmd  = {8'h9A, 8'hC5, 8'h84};
    req_wd   = {8'h3C, 8'h00, 8'h65};
    sie_busy = 1'b0;
    regrd    = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_sie_en", sie_en, 1'b0);
    chk("rst_cmd", cmd, 8'h00);
    chk("rst_regwd", regwd, 8'h00);
    chk("rst_rd", rd, 8'h00);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write from requester 0; junk on regrd must not reach rd.
    req = 3'b001;
    run_txn("wr0", 3'b001, 8'h84, 8'h65, 1, 2, 4, 8'h5A, 8'h00, 1'b0);
    req = '0;
    @(negedge clk);
    chk("wr0_done_once", done, 3'b000);

    // Register read from requester 1.
    req = 3'b010;
    run_txn("rd1", 3'b010, 8'hC5, 8'h00, 1, 2, 4, 8'h24, 8'h24, 1'b0);
    req = '0;
    @(negedge clk);

    // SIE busy at request: no grant until it drops; req dropped mid-transaction.
    sie_busy = 1'b1;
    req      = 3'b100;
    repeat (3) @(negedge clk);
    chk("busy_gnt", gnt, 3'b000);
    chk("busy_sie_en", sie_en, 1'b0);
    sie_busy = 1'b0;
    run_txn("busy2", 3'b100, 8'h9A, 8'h3C, 1, 1, 3, 8'h66, 8'h24, 1'b1);
    @(negedge clk);

    // All three requesting with ptr back at 0: strict rotation.
    req = 3'b111;
    run_txn("rr_a", 3'b001, 8'h84, 8'h65, 1, 2, 4, 8'h77, 8'h24, 1'b0);
    run_txn("rr_b", 3'b010, 8'hC5, 8'h00, 1, 2, 4, 8'h31, 8'h31, 1'b0);
    run_txn("rr_c", 3'b100, 8'h9A, 8'h3C, 1, 1, 2, 8'h66, 8'h31, 1'b0);
    run_txn("rr_d", 3'b001, 8'h84, 8'h65, 1, 2, 4, 8'h77, 8'h31, 1'b0);
    req = '0;
    @(negedge clk);

    // SIE never acknowledges.
    req = 3'b010;
`ifdef ULPI_ARB_TIMEOUT_EN
    push_exp(3'b010, 8'h31, 1'b1);
    wait_sie_en(n);
    chk("to_en_lat", n, 1);
    wait_done(n);
    chk("to_lat", n, TO_CYC);
    chk("to_sie_en", sie_en, 1'b0);
    pop_cmp("to");
    req = '0;
    @(negedge clk);
`else
    wait_sie_en(n);
    chk("noto_en_lat", n, 1);
    repeat (TO_CYC + 4) @(negedge clk);
    chk("noto_sie_en", sie_en, 1'b1);
    chk("noto_gnt", gnt, 3'b010);
    chk("noto_done", done, 3'b000);
    chk("noto_err", err, 1'b0);
    run_txn("noto_fin", 3'b010, 8'hC5, 8'h00, 1, 0, 2, 8'h42, 8'h42, 1'b0);
    req = '0;
    @(negedge clk);
`endif

    // Reset while waiting in WDONE.
    req = 3'b001;
    wait_sie_en(n);
    chk("mid_en_lat", n, 1);
    sie_busy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_sie_en", sie_en, 1'b0);
    chk("mid_gnt", gnt, 3'b000);
    chk("mid_done", done, 3'b000);
    chk("mid_rd", rd, 8'h00);
    chk("mid_cmd", cmd, 8'h00);
    chk("mid_regwd", regwd, 8'h00);
    chk("mid_err", err, 1'b0);
    sie_busy = 1'b0;
    req      = '0;
    repeat (3) @(negedge clk);
    chk("mid_no_done", done, 3'b000);
    rst_n = 1'b1;
    req   = 3'b010;
    run_txn("post_rst", 3'b010, 8'hC5, 8'h00, 1, 2, 4, 8'h11, 8'h11, 1'b0);
    req = '0;
    @(negedge clk);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
